// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO behind a UART receiver with fill level, sticky overflow and per-byte irq
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 i_Clock,
  input  logic                 reset,
  input  logic                 i_Rx_DV,
  input  logic [7:0]           i_Rx_Byte,
  input  logic                 i_Rd,
  input  logic                 i_Clr_Ovf,
  output logic [7:0]           o_Data,
  output logic                 o_Empty,
  output logic                 o_Full,
  output logic [ADDR_BITS:0]   o_Count,
  output logic                 o_Overflow,
  output logic                 o_Irq
);
  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(DEPTH);
  logic [7:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 ovf_q, ovf_d, irq_q, irq_d;
  logic                 wr_en, rd_en;
  assign o_Empty    = count_q == '0;
  assign o_Full     = count_q == FULL_CNT;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_Irq      = irq_q;
  assign o_Data     = o_Empty ? 8'h00 : mem[rd_ptr_q];
  // a full FIFO still accepts a byte when the head is popped in the same cycle
  always_comb begin
    rd_en    = i_Rd & ~o_Empty;
    wr_en    = i_Rx_DV & (~o_Full | rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (wr_en & ~rd_en) ? count_q + 1'b1 :
               (rd_en & ~wr_en) ? count_q - 1'b1 : count_q;
    ovf_d    = (i_Rx_DV & o_Full & ~rd_en) | (ovf_q & ~i_Clr_Ovf);
    irq_d    = wr_en;
  end
  // pointer, level and flag state; reset discards all buffered bytes
  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end
  // byte storage, deliberately not reset
  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_ptr_q] <= i_Rx_Byte;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus checked against a queue model every cycle plus literal expectations
module tb_uart_rx_fifo;
  logic       i_Clock = 0, reset = 1, i_Rx_DV = 0, i_Rd = 0, i_Clr_Ovf = 0;
  logic [7:0] i_Rx_Byte = 0, o_Data;
  logic       o_Empty, o_Full, o_Overflow, o_Irq;
  logic [4:0] o_Count;
  int n_chk = 0, n_pass = 0;
  logic [7:0] q[$];
  bit m_ovf = 0, m_irq = 0, chk_on = 0;
  logic [7:0] exp_rd;

  uart_rx_fifo #(.DEPTH(16), .ADDR_BITS(4)) dut (
    .i_Clock(i_Clock), .reset(reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .i_Rd(i_Rd), .i_Clr_Ovf(i_Clr_Ovf), .o_Data(o_Data), .o_Empty(o_Empty),
    .o_Full(o_Full), .o_Count(o_Count), .o_Overflow(o_Overflow), .o_Irq(o_Irq));

  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: a byte queue following the accept/drop rules
  always @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      q.delete(); m_ovf = 0; m_irq = 0;
    end else begin
      bit rd, wr, full;
      full = q.size() == 16;
      rd = i_Rd && q.size() > 0;
      wr = i_Rx_DV && (!full || rd);
      m_ovf = (i_Rx_DV && full && !rd) || (m_ovf && !i_Clr_Ovf);
      m_irq = wr;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(i_Rx_Byte);
    end
  end

  always @(negedge i_Clock) if (chk_on) begin
    chk("m_empty", o_Empty, q.size() == 0);
    chk("m_full", o_Full, q.size() == 16);
    chk("m_count", o_Count, q.size());
    chk("m_data", o_Data, q.size() > 0 ? q[0] : 8'h00);
    chk("m_ovf", o_Overflow, m_ovf);
    chk("m_irq", o_Irq, m_irq);
  end

  task automatic step(input bit dv, input logic [7:0] b, input bit rd, input bit clr);
    i_Rx_DV = dv; i_Rx_Byte = b; i_Rd = rd; i_Clr_Ovf = clr;
    @(negedge i_Clock);
    i_Rx_DV = 0; i_Rd = 0; i_Clr_Ovf = 0;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge i_Clock);
    chk("rst_empty", o_Empty, 1); chk("rst_count", o_Count, 0);
    chk("rst_data", o_Data, 8'h00); chk("rst_ovf", o_Overflow, 0); chk("rst_irq", o_Irq, 0);
    reset = 0; chk_on = 1;
    step(1, 8'hA5, 0, 0); chk("b_irq1", o_Irq, 1); chk("b_cnt1", o_Count, 1);
    step(1, 8'h3C, 0, 0); chk("b_irq2", o_Irq, 1); chk("b_cnt2", o_Count, 2); chk("b_data", o_Data, 8'hA5);
    step(0, 0, 0, 0); chk("b_irq0", o_Irq, 0);
    step(0, 0, 1, 0); chk("b_pop1", o_Data, 8'h3C); chk("b_pcnt", o_Count, 1);
    step(0, 0, 1, 0); chk("b_pop2e", o_Empty, 1); chk("b_pop2d", o_Data, 8'h00);
    step(0, 0, 1, 0); chk("rd_empty_cnt", o_Count, 0); chk("rd_empty_e", o_Empty, 1);
    fill16(); chk("f_full", o_Full, 1); chk("f_cnt", o_Count, 16);
    step(1, 8'hFF, 0, 0); chk("f_ovf", o_Overflow, 1); chk("f_cnt2", o_Count, 16); chk("f_irq", o_Irq, 0);
    for (int i = 0; i < 16; i++) begin chk("f_drain", o_Data, 8'(i)); step(0, 0, 1, 0); end
    chk("f_empty", o_Empty, 1);
    step(0, 0, 0, 1); chk("f_clr", o_Overflow, 0);
    fill16();
    step(1, 8'h55, 1, 0); chk("s_cnt", o_Count, 16); chk("s_ovf", o_Overflow, 0); chk("s_data", o_Data, 8'h01);
    for (int i = 1; i < 16; i++) begin chk("s_drain", o_Data, 8'(i)); step(0, 0, 1, 0); end
    chk("s_last", o_Data, 8'h55); step(0, 0, 1, 0); chk("s_empty", o_Empty, 1);
    fill16();
    step(1, 8'hAA, 0, 1); chk("c_setwins", o_Overflow, 1);
    step(0, 0, 0, 1); chk("c_clr", o_Overflow, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
    step(1, 8'h77, 1, 0); chk("e_cnt", o_Count, 1); chk("e_data", o_Data, 8'h77);
    step(0, 0, 1, 0); chk("e_empty", o_Empty, 1);
    exp_rd = 0;
    for (int i = 0; i < 40; i++) begin
      bit pop;
      pop = o_Count >= 3;
      if (pop) begin chk("w_data", o_Data, exp_rd); exp_rd++; end
      step(1, 8'(i), pop, 0);
      if (o_Count > 5) chk("w_max", o_Count, 5);
    end
    for (int k = 0; k < 10 && !o_Empty; k++) begin chk("w_data", o_Data, exp_rd); exp_rd++; step(0, 0, 1, 0); end
    chk("w_all", exp_rd, 40);
    fill16(); step(1, 8'hEE, 0, 0);
    for (int i = 0; i < 13; i++) step(0, 0, 1, 0);
    chk("a_pre_cnt", o_Count, 3); chk("a_pre_ovf", o_Overflow, 1);
    #2 reset = 1;
    #1 chk("a_empty", o_Empty, 1); chk("a_cnt", o_Count, 0); chk("a_ovf", o_Overflow, 0);
    chk("a_data", o_Data, 8'h00); chk("a_irq", o_Irq, 0);
    @(negedge i_Clock); reset = 0;
    step(1, 8'h12, 0, 0); chk("a_resume", o_Data, 8'h12);
    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures every byte the receiver presents with its one-cycle data-valid strobe, holds the bytes in FIFO order, and exposes them to the CPU/memory-mapped I/O side through a first-word-fall-through pop interface. It also reports buffer fill level, a sticky overflow flag and a per-byte interrupt pulse, so software need not poll the receiver every byte time.

## Interface

**Parameters**
- `DEPTH`, default 16: number of byte entries. Must be a power of two, 2..256.
- `ADDR_BITS`, default 4: log2(`DEPTH`). Must match `DEPTH`.

**Ports**
- `i_Clock`  input  1: system clock. All logic is rising-edge.
- `reset`  input  1: one clock; reset is asynchronous and active-high.
- `i_Rx_DV`  input  1: one-cycle strobe from the receiver; the byte on `i_Rx_Byte` is valid this cycle.
- `i_Rx_Byte`  input  8: received byte.
- `i_Rd`  input  1: pop strobe. Consumes the head byte at the clock edge.
- `i_Clr_Ovf`  input  1: clears `o_Overflow`.
- `o_Data`  output  8: head byte (first-word fall-through). Drives 8'h00 when empty.
- `o_Empty`  output  1: FIFO holds 0 bytes.
- `o_Full`  output  1: FIFO holds `DEPTH` bytes.
- `o_Count`  output  `ADDR_BITS`+1: number of bytes held, 0..`DEPTH`.
- `o_Overflow`  output  1: sticky flag; a byte was dropped.
- `o_Irq`  output  1: one-cycle pulse per accepted byte.

## Operation

- **Storage and pointers**
  - Storage: `DEPTH` x 8 register array. It is not reset.
  - Pointers: `wr_ptr` and `rd_ptr`, each `ADDR_BITS` wide, plus a `count` register of width `ADDR_BITS`+1.
  - Both pointers wrap modulo `DEPTH` by natural overflow.
- **Write accept:** `wr_en = i_Rx_DV & (~o_Full | rd_en)`. On `wr_en`, `mem[wr_ptr] <= i_Rx_Byte` and `wr_ptr` increments.
- **Read accept:** `rd_en = i_Rd & ~o_Empty`. On `rd_en`, `rd_ptr` increments.
  - Pop on empty is ignored; no state changes.
- **Count update:**
  - +1 when `wr_en` only.
  - −1 when `rd_en` only.
  - Unchanged when both or neither.
- **Flags:** `o_Empty = (count == 0)`, `o_Full = (count == DEPTH)`, `o_Count = count`, all decoded from registered state.
- **Head byte:** `o_Data = o_Empty ? 8'h00 : mem[rd_ptr]`.
- **Simultaneous write and read**
  - When full: both are performed. The head is consumed and the new byte is stored in the freed slot. Count stays `DEPTH` and no overflow is raised.
  - When empty: the read is ignored and the write is performed. Count becomes 1.
- **Overflow:** `i_Rx_DV & o_Full & ~rd_en` drops the byte.
  - Memory, pointers and count are unchanged.
  - `o_Overflow` sets to 1 at that edge.
- **Overflow clear:** `i_Clr_Ovf` clears `o_Overflow` at the edge. If an overflow event occurs in the same cycle, set wins and the flag stays 1.
- **Interrupt:** `o_Irq` is registered: `o_Irq <= wr_en`.
- **No state machine beyond the pointers and counter.** Behaviour is fully defined by the update rules above.

## Timing

- **Reset:** asserting `reset` immediately (asynchronously) forces:
  - `wr_ptr = rd_ptr = count = 0`
  - `o_Empty = 1`, `o_Full = 0`, `o_Count = 0`
  - `o_Overflow = 0`, `o_Irq = 0`, `o_Data = 8'h00`
- **Reset mid-operation:** all buffered bytes are discarded. A `i_Rx_DV` coinciding with reset is lost. Normal operation resumes on the first edge after deassertion.
- **Write latency:** byte strobed at edge N is visible after edge N:
  - `o_Empty` falls, `o_Count` increments and `o_Data` shows the byte (if it is the head).
  - `o_Irq` is high for exactly the cycle following edge N.
- **Read latency:** `i_Rd` sampled at edge M. After M, `o_Data` shows the next byte, or 8'h00 if the FIFO became empty. Data is valid to sample combinationally in the same cycle `i_Rd` is asserted.
- **Back-to-back operation:** one write and one read per cycle are sustained indefinitely. The receiver strobes at most once per bit time, but the FIFO must not assume any spacing.
- **Hold requirements:** `i_Rd` and `i_Clr_Ovf` are level-sampled each edge. Holding `i_Rd` high pops one byte per cycle until empty.

## Test plan

- **Async reset:** assert `reset` between clock edges with 3 bytes buffered and `o_Overflow` = 1 → before the next edge: `o_Empty` = 1, `o_Count` = 0, `o_Overflow` = 0, `o_Data` = 00, `o_Irq` = 0.
- **Basic order:** strobe A5 then 3C →
  - `o_Count` = 2, `o_Data` = A5, `o_Irq` pulses twice for one cycle each.
  - Pop → `o_Data` = 3C, count 1. Pop → `o_Empty` = 1, `o_Data` = 00.
- **Fill and overflow:** write 00..0F → `o_Full` = 1, `o_Count` = 16.
  - Write FF → `o_Overflow` = 1, count 16, no `o_Irq`.
  - Drain → 00..0F in order, FF never appears.
  - Pulse `i_Clr_Ovf` → 0.
- **Full with simultaneous read/write:** FIFO full with 00..0F; same cycle `i_Rx_DV` with 55 and `i_Rd` →
  - Count stays 16, `o_Overflow` = 0, `o_Data` = 01.
  - Draining yields 01..0F then 55.
- **Wrap-around:** 40 bytes 00..27 with interleaved pops, count never exceeding 5 → every byte read back in order across multiple pointer wraps.
- **Edge cases:**
  - `i_Rd` while empty → no change, count 0.
  - `i_Clr_Ovf` asserted in the same cycle as an overflow event → `o_Overflow` = 1.
  - Simultaneous write+read on empty → count 1, `o_Data` = written byte.
